// File: rtl/id_pkg.sv
// Shared decode encodings for the instruction-decode stage: exe commands, modes,
// condition codes, ARM data-processing opcodes and the ID/EXE bubble constant.
package id_pkg;

  typedef enum logic [3:0] {
    CmdNop = 4'b0000,
    CmdMov = 4'b0001,
    CmdAdd = 4'b0010,
    CmdAdc = 4'b0011,
    CmdSub = 4'b0100,
    CmdSbc = 4'b0101,
    CmdAnd = 4'b0110,
    CmdOrr = 4'b0111,
    CmdEor = 4'b1000,
    CmdMvn = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    ModeAlu    = 2'b00,
    ModeMem    = 2'b01,
    ModeBranch = 2'b10,
    ModeNone   = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    CondEq, CondNe, CondCs, CondCc, CondMi, CondPl, CondVs, CondVc,
    CondHi, CondLs, CondGe, CondLt, CondGt, CondLe, CondAl, CondNv
  } cond_e;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpMvn = 4'b1111;

  typedef struct packed {
    logic     valid;
    exe_cmd_e exe_cmd;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     wb_en;
    logic     s;
    logic     b;
  } ctrl_t;

  localparam ctrl_t Bubble = ctrl_t'('0);

  // Flags arrive as {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
    logic n, z, c, v;
    {n, z, c, v} = sr;
    case (cond_e'(cond))
      CondEq:  return z;
      CondNe:  return !z;
      CondCs:  return c;
      CondCc:  return !c;
      CondMi:  return n;
      CondPl:  return !n;
      CondVs:  return v;
      CondVc:  return !v;
      CondHi:  return c && !z;
      CondLs:  return !c || z;
      CondGe:  return n == v;
      CondLt:  return n != v;
      CondGt:  return !z && (n == v);
      CondLe:  return z || (n != v);
      CondAl:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Bundle of fetch, write-back, hazard-check and ID/EXE signals around the decode stage.
interface id_stage_pipe_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16,
  parameter int unsigned PC_W    = 32
);
  localparam int unsigned ADDR_W = $clog2(REG_CNT);

  logic              if_valid;
  logic [31:0]       instr_in;
  logic [PC_W-1:0]   pc_in;
  logic [3:0]        sr_in;
  logic              wb_wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              exe_wb_en;
  logic [ADDR_W-1:0] exe_dest;
  logic              mem_wb_en;
  logic [ADDR_W-1:0] mem_dest;
  logic              flush;
  logic              stall_out;

  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [DATA_W-1:0] id_val_rn;
  logic [DATA_W-1:0] id_val_rm;
  logic [3:0]        id_exe_cmd;
  logic              id_mem_r_en;
  logic              id_mem_w_en;
  logic              id_wb_en;
  logic              id_s;
  logic              id_b;
  logic              id_imm;
  logic [11:0]       id_shift_op;
  logic [23:0]       id_simm24;
  logic [ADDR_W-1:0] id_dest;

  modport master (
    output if_valid, instr_in, pc_in, sr_in, wb_wb_en, wb_dest, wb_value,
           exe_wb_en, exe_dest, mem_wb_en, mem_dest, flush,
    input  stall_out, id_valid, id_pc, id_val_rn, id_val_rm, id_exe_cmd, id_mem_r_en,
           id_mem_w_en, id_wb_en, id_s, id_b, id_imm, id_shift_op, id_simm24, id_dest
  );

  modport slave (
    input  if_valid, instr_in, pc_in, sr_in, wb_wb_en, wb_dest, wb_value,
           exe_wb_en, exe_dest, mem_wb_en, mem_dest, flush,
    output stall_out, id_valid, id_pc, id_val_rn, id_val_rm, id_exe_cmd, id_mem_r_en,
           id_mem_w_en, id_wb_en, id_s, id_b, id_imm, id_shift_op, id_simm24, id_dest
  );

endinterface

// File: rtl/id_regfile.sv
// Register file: two combinational read ports, one clocked write port.
// Build option ID_WB_BYPASS_EN forwards a same-cycle write to the read ports.
module id_regfile #(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned REG_CNT = 16,
  localparam int unsigned ADDR_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'(REG_CNT);

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic              w_ok;

  assign w_ok = we && ({1'b0, waddr} < AddrLimit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_CNT); i++) regs_q[i] <= '0;
    end else if (w_ok) begin
      regs_q[waddr] <= wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = ({1'b0, addr} < AddrLimit) ? regs_q[addr] : '0;
`ifdef ID_WB_BYPASS_EN
    if (w_ok && (addr == waddr)) val = wdata;
`endif
    return val;
  endfunction

  always_comb begin
    rdata_a = read_port(raddr_a);
    rdata_b = read_port(raddr_b);
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with hazard detection and ID/EXE pipeline register.
// ID_WB_BYPASS_EN enables same-cycle write-back forwarding in the register file.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16,
  parameter int unsigned PC_W    = 32
) (
  input logic            clk,
  input logic            rst,
  id_stage_pipe_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(REG_CNT);

  logic [3:0]        cond;
  logic [3:0]        opcode;
  logic [1:0]        mode;
  logic              s_bit;
  logic              i_bit;
  logic [ADDR_W-1:0] rn, rd, rm, src2;
  logic [DATA_W-1:0] val_rn, val_rm;

  ctrl_t dec;
  logic  use_rn, two_src, exe_hit, mem_hit, hazard, issue;

  assign cond   = bus.instr_in[31:28];
  assign mode   = bus.instr_in[27:26];
  assign i_bit  = bus.instr_in[25];
  assign opcode = bus.instr_in[24:21];
  assign s_bit  = bus.instr_in[20];
  assign rn     = ADDR_W'(bus.instr_in[19:16]);
  assign rd     = ADDR_W'(bus.instr_in[15:12]);
  assign rm     = ADDR_W'(bus.instr_in[3:0]);

  always_comb begin
    dec       = Bubble;
    dec.valid = 1'b1;
    use_rn    = 1'b1;
    unique case (mode_e'(mode))
      ModeAlu: begin
        dec.wb_en = 1'b1;
        dec.s     = s_bit;
        unique case (opcode)
          OpMov: begin dec.exe_cmd = CmdMov; use_rn = 1'b0; end
          OpMvn: begin dec.exe_cmd = CmdMvn; use_rn = 1'b0; end
          OpAdd: dec.exe_cmd = CmdAdd;
          OpAdc: dec.exe_cmd = CmdAdc;
          OpSub: dec.exe_cmd = CmdSub;
          OpSbc: dec.exe_cmd = CmdSbc;
          OpAnd: dec.exe_cmd = CmdAnd;
          OpOrr: dec.exe_cmd = CmdOrr;
          OpEor: dec.exe_cmd = CmdEor;
          OpCmp: begin dec.exe_cmd = CmdSub; dec.wb_en = 1'b0; dec.s = 1'b1; end
          OpTst: begin dec.exe_cmd = CmdAnd; dec.wb_en = 1'b0; dec.s = 1'b1; end
          default: begin dec.wb_en = 1'b0; dec.s = 1'b0; end
        endcase
      end
      ModeMem: begin
        dec.exe_cmd = CmdAdd;
        if (s_bit) begin
          dec.mem_r_en = 1'b1;
          dec.wb_en    = 1'b1;
        end else begin
          dec.mem_w_en = 1'b1;
        end
      end
      ModeBranch: begin
        dec.b  = 1'b1;
        use_rn = 1'b0;
      end
      ModeNone: ;
    endcase
  end

  // Stores read the data to be written through the second port.
  assign src2    = dec.mem_w_en ? rd : rm;
  assign two_src = ~i_bit | dec.mem_w_en;

  assign exe_hit = bus.exe_wb_en &
                   ((use_rn & (bus.exe_dest == rn)) | (two_src & (bus.exe_dest == src2)));
  assign mem_hit = bus.mem_wb_en &
                   ((use_rn & (bus.mem_dest == rn)) | (two_src & (bus.mem_dest == src2)));
  assign hazard  = bus.if_valid & (exe_hit | mem_hit);
  assign issue   = bus.if_valid & ~hazard & cond_pass(cond, bus.sr_in);

  assign bus.stall_out = hazard & ~bus.flush;

  id_regfile #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.wb_wb_en),
    .waddr   (bus.wb_dest),
    .wdata   (bus.wb_value),
    .raddr_a (rn),
    .rdata_a (val_rn),
    .raddr_b (src2),
    .rdata_b (val_rm)
  );

  ctrl_t             ctrl_d, ctrl_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] val_rn_q, val_rm_q;
  logic              imm_q;
  logic [11:0]       shift_q;
  logic [23:0]       simm_q;
  logic [ADDR_W-1:0] dest_q;

  assign ctrl_d = (bus.flush || !issue) ? Bubble : dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= Bubble;
      pc_q     <= '0;
      val_rn_q <= '0;
      val_rm_q <= '0;
      imm_q    <= 1'b0;
      shift_q  <= '0;
      simm_q   <= '0;
      dest_q   <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      pc_q     <= bus.pc_in;
      val_rn_q <= val_rn;
      val_rm_q <= val_rm;
      imm_q    <= i_bit;
      shift_q  <= bus.instr_in[11:0];
      simm_q   <= bus.instr_in[23:0];
      dest_q   <= rd;
    end
  end

  assign bus.id_valid    = ctrl_q.valid;
  assign bus.id_exe_cmd  = ctrl_q.exe_cmd;
  assign bus.id_mem_r_en = ctrl_q.mem_r_en;
  assign bus.id_mem_w_en = ctrl_q.mem_w_en;
  assign bus.id_wb_en    = ctrl_q.wb_en;
  assign bus.id_s        = ctrl_q.s;
  assign bus.id_b        = ctrl_q.b;
  assign bus.id_pc       = pc_q;
  assign bus.id_val_rn   = val_rn_q;
  assign bus.id_val_rm   = val_rm_q;
  assign bus.id_imm      = imm_q;
  assign bus.id_shift_op = shift_q;
  assign bus.id_simm24   = simm_q;
  assign bus.id_dest     = dest_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed cases plus random instructions
// against a table-driven reference model of the decode stage.
module tb_id_stage_pipe;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_CNT = 16;
  localparam int unsigned PC_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .PC_W(PC_W)) bus ();

  id_stage_pipe #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        full;
    logic        valid;
    logic [3:0]  cmd;
    logic        r, w, wb, s, b;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest;
  } exp_t;

  // Data-processing opcode -> {defined, exe_cmd}
  localparam logic [4:0] ALU_TAB [16] = '{
    5'h16, 5'h18, 5'h14, 5'h00, 5'h12, 5'h13, 5'h15, 5'h00,
    5'h16, 5'h00, 5'h14, 5'h00, 5'h17, 5'h11, 5'h00, 5'h19
  };

  logic [31:0] ref_rf [16];
  exp_t        idq [$];
  string       idn [$];
  logic        stallq [$];
  string       stn [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    return base ^ c[0];
  endfunction

  function automatic logic [31:0] rd_ref(input logic [3:0] a);
`ifdef ID_WB_BYPASS_EN
    if (bus.wb_wb_en && bus.wb_dest == a) return bus.wb_value;
`endif
    return ref_rf[a];
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("v=%b cmd=%h r=%b w=%b wb=%b s=%b b=%b pc=%h rn=%h rm=%h imm=%b sh=%h simm=%h dest=%h",
                     e.valid, e.cmd, e.r, e.w, e.wb, e.s, e.b, e.pc, e.rn, e.rm, e.imm, e.sh,
                     e.simm, e.dest);
  endfunction

  task automatic set_idle();
    bus.if_valid  = 1'b0;
    bus.instr_in  = '0;
    bus.pc_in     = '0;
    bus.sr_in     = '0;
    bus.wb_wb_en  = 1'b0;
    bus.wb_dest   = '0;
    bus.wb_value  = '0;
    bus.exe_wb_en = 1'b0;
    bus.exe_dest  = '0;
    bus.mem_wb_en = 1'b0;
    bus.mem_dest  = '0;
    bus.flush     = 1'b0;
  endtask

  // Called at posedge+1 with inputs applied; queues expectations, advances one cycle.
  task automatic issue(input string name, input bit rst_after = 1'b0);
    exp_t        e;
    logic [31:0] ins;
    logic [3:0]  op, rn, rd, rm, src2;
    logic [1:0]  mode;
    logic        st, ld, two, use_n, haz;
    ins   = bus.instr_in;
    mode  = ins[27:26];
    op    = ins[24:21];
    rn    = ins[19:16];
    rd    = ins[15:12];
    rm    = ins[3:0];
    st    = (mode == 2'd1) && !ins[20];
    ld    = (mode == 2'd1) && ins[20];
    src2  = st ? rd : rm;
    two   = !ins[25] || st;
    use_n = !((mode == 2'd2) || ((mode == 2'd0) && (op == 4'd13 || op == 4'd15)));
    haz   = bus.if_valid &&
            ((bus.exe_wb_en && ((use_n && bus.exe_dest == rn) || (two && bus.exe_dest == src2))) ||
             (bus.mem_wb_en && ((use_n && bus.mem_dest == rn) || (two && bus.mem_dest == src2))));
    stallq.push_back(haz && !bus.flush);
    stn.push_back(name);
    e = '0;
    e.full = 1'b1;
    if (!rst) begin
      e.pc   = bus.pc_in;
      e.rn   = rd_ref(rn);
      e.rm   = rd_ref(src2);
      e.imm  = ins[25];
      e.sh   = ins[11:0];
      e.simm = ins[23:0];
      e.dest = rd;
      if (bus.if_valid && !bus.flush && !haz && cond_ok(ins[31:28], bus.sr_in)) begin
        e.valid = 1'b1;
        case (mode)
          2'd0: if (ALU_TAB[op][4]) begin
            e.cmd = ALU_TAB[op][3:0];
            e.wb  = !(op == 4'd8 || op == 4'd10);
            e.s   = (op == 4'd8 || op == 4'd10) ? 1'b1 : ins[20];
          end
          2'd1: begin e.cmd = 4'b0010; e.r = ld; e.w = st; e.wb = ld; end
          2'd2: e.b = 1'b1;
          default: ;
        endcase
      end else begin
        e.full = 1'b0;
      end
      if (bus.wb_wb_en) ref_rf[bus.wb_dest] = bus.wb_value;
    end
    @(posedge clk);
    #1;
    if (rst_after) begin
      rst = 1'b1;
      for (int i = 0; i < 16; i++) ref_rf[i] = '0;
      e = '0;
      e.full = 1'b1;
      name = {name, "_async"};
    end
    idq.push_back(e);
    idn.push_back(name);
  endtask

  initial begin : monitor
    exp_t  e, a;
    logic  es;
    string nm;
    forever begin
      @(negedge clk);
      if (stallq.size() > 0) begin
        es = stallq.pop_front();
        nm = stn.pop_front();
        n_checks++;
        if (bus.stall_out === es) n_pass++;
        else $display("FAIL stall[%s]: got %b expected %b", nm, bus.stall_out, es);
      end
      if (idq.size() > 0) begin
        e  = idq.pop_front();
        nm = idn.pop_front();
        a  = '0;
        a.full  = e.full;
        a.valid = bus.id_valid;
        a.cmd   = bus.id_exe_cmd;
        a.r     = bus.id_mem_r_en;
        a.w     = bus.id_mem_w_en;
        a.wb    = bus.id_wb_en;
        a.s     = bus.id_s;
        a.b     = bus.id_b;
        if (e.full) begin
          a.pc   = bus.id_pc;
          a.rn   = bus.id_val_rn;
          a.rm   = bus.id_val_rm;
          a.imm  = bus.id_imm;
          a.sh   = bus.id_shift_op;
          a.simm = bus.id_simm24;
          a.dest = bus.id_dest;
        end else begin
          e.pc = '0; e.rn = '0; e.rm = '0; e.imm = 1'b0; e.sh = '0; e.simm = '0; e.dest = '0;
        end
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL id[%s]: got %s expected %s", nm, fmt(a), fmt(e));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    logic [31:0] ins;
    for (int i = 0; i < 16; i++) ref_rf[i] = '0;
    set_idle();
    @(posedge clk);
    #1;
    issue("reset0");
    issue("reset1");
    rst = 1'b0;

    set_idle(); bus.wb_wb_en = 1'b1; bus.wb_dest = 4'd3; bus.wb_value = 32'h0000_00AA;
    issue("wr_r3");
    set_idle(); bus.if_valid = 1'b1; bus.instr_in = 32'hE083_1003; bus.pc_in = 32'h100;
    issue("add_r1_r3_r3");
    bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd3;
    issue("raw_exe");
    bus.exe_wb_en = 1'b0;
    issue("raw_cleared");
    bus.mem_wb_en = 1'b1; bus.mem_dest = 4'd3;
    issue("raw_mem");
    bus.mem_wb_en = 1'b0; bus.instr_in = 32'h0083_1003;
    issue("addeq_z0");
    bus.sr_in = 4'b0100;
    issue("addeq_z1");
    bus.sr_in = 4'b0000; bus.instr_in = 32'hE083_1003;
    bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd3; bus.flush = 1'b1;
    issue("flush_haz");
    bus.flush = 1'b0; bus.instr_in = 32'hE1A3_1002;
    issue("mov_rn_excluded");
    bus.exe_dest = 4'd1; bus.instr_in = 32'hE583_1000;
    issue("str_rd_haz");
    set_idle(); bus.if_valid = 1'b1; bus.instr_in = 32'hE083_1003;
    bus.wb_wb_en = 1'b1; bus.wb_dest = 4'd3; bus.wb_value = 32'h55;
    issue("wb_same_cycle");
    bus.wb_wb_en = 1'b0;
    issue("wb_after");

    for (int k = 0; k < 300; k++) begin
      ins = $urandom();
      if ($urandom_range(0, 9) < 7) ins[31:28] = 4'hE;
      bus.instr_in  = ins;
      bus.if_valid  = ($urandom_range(0, 9) != 0);
      bus.pc_in     = $urandom();
      bus.sr_in     = 4'($urandom_range(0, 15));
      bus.wb_wb_en  = $urandom_range(0, 1) == 1;
      bus.wb_dest   = 4'($urandom_range(0, 15));
      bus.wb_value  = $urandom();
      bus.exe_wb_en = $urandom_range(0, 9) < 3;
      bus.exe_dest  = $urandom_range(0, 1) ? ins[19:16] : 4'($urandom_range(0, 15));
      bus.mem_wb_en = $urandom_range(0, 9) < 3;
      bus.mem_dest  = $urandom_range(0, 1) ? ins[3:0] : 4'($urandom_range(0, 15));
      bus.flush     = $urandom_range(0, 9) == 0;
      issue("random");
    end

    set_idle(); bus.wb_wb_en = 1'b1; bus.wb_dest = 4'd5; bus.wb_value = 32'h1234;
    issue("wr_r5");
    set_idle(); bus.if_valid = 1'b1; bus.instr_in = 32'hE085_1005; bus.pc_in = 32'h200;
    issue("pre_rst");
    bus.instr_in = 32'hE083_2005; bus.pc_in = 32'h204;
    issue("rst_mid", 1'b1);
    set_idle();
    issue("rst_hold");
    rst = 1'b0;
    for (int r = 0; r < 16; r++) begin
      set_idle();
      bus.if_valid = 1'b1;
      bus.instr_in = 32'hE080_0000 | (32'(r) << 16) | 32'(r);
      bus.pc_in    = 32'h300 + 32'(r);
      issue($sformatf("read_r%0d_after_rst", r));
    end
    set_idle();

    for (int t = 0; t < 5 && (idq.size() > 0 || stallq.size() > 0); t++) @(negedge clk);
    if (idq.size() > 0 || stallq.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", idq.size() + stallq.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
